// File: rtl/hamming_dec_engine_if.sv
// Start/done handshake and shared data-memory port of the Hamming(15,11) decoder.
// The engine takes the master side; the core/memory side takes the slave side.
interface hamming_dec_engine_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          init;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [7:0]    err_cnt;

    modport master (
        input  init,
        input  mem_rdata,
        output done,
        output mem_addr,
        output mem_wr_en,
        output mem_wdata,
        output err_cnt
    );

    modport slave (
        output init,
        output mem_rdata,
        input  done,
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wdata,
        input  err_cnt
    );
endinterface

// File: rtl/hamming_dec_engine.sv
// Hamming(15,11) single-error-correcting decoder: reads NWORDS encoded byte pairs,
// corrects one flipped bit per word, and writes the 11-bit messages back to memory.
module hamming_dec_engine #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int SRC_BASE = 64,
    parameter int DST_BASE = 94,
    parameter int NWORDS   = 15
) (
    input logic                  clk,
    input logic                  reset,
    hamming_dec_engine_if.master bus
);
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [2:0] {IDLE, RLO, RHI, CAP, WLO, WHI} state_t;

    // Codeword position of the n-th data bit: the n-th index in 1..15 that is not a power of two.
    function automatic int data_pos(input int n);
        int cnt;
        cnt      = 0;
        data_pos = 0;
        for (int p = 1; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == n) data_pos = p;
                cnt++;
            end
        end
    endfunction

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          done_q, done_d;
    logic [7:0]    err_q, err_d;
    logic [7:0]    lo_q, lo_d;
    logic [6:0]    hi_q, hi_d;

    logic [15:1]   cw;
    logic [3:0]    syn;
    logic [10:0]   msg;
    logic [AW-1:0] word_off, src_addr, dst_addr;
    logic [AW-1:0] addr_c;
    logic          we_c;
    logic [DW-1:0] wdata_c;

    // hi[7] of the encoded pair carries nothing and is never stored.
    assign cw = {hi_q, lo_q};

    for (genvar gi = 0; gi < 4; gi++) begin : g_syn
        logic [15:1] sel;
        for (genvar gj = 1; gj < 16; gj++) begin : g_sel
            if (((gj >> gi) & 1) == 1) begin : g_on
                assign sel[gj] = cw[gj];
            end else begin : g_off
                assign sel[gj] = 1'b0;
            end
        end
        assign syn[gi] = ^sel;
    end

    // The syndrome names the flipped position directly, so only data positions need fixing.
    for (genvar gi = 0; gi < 11; gi++) begin : g_ext
        localparam int POS = data_pos(gi);
        assign msg[gi] = cw[POS] ^ (syn == 4'(POS));
    end

    assign word_off = AW'({idx_q, 1'b0});
    assign src_addr = AW'(SRC_BASE) + word_off;
    assign dst_addr = AW'(DST_BASE) + word_off;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = done_q;
        err_d   = err_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        addr_c  = '0;
        we_c    = 1'b0;
        wdata_c = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.init) begin
                    idx_d   = '0;
                    err_d   = '0;
                    done_d  = 1'b0;
                    state_d = RLO;
                end
            end
            RLO: begin
                addr_c  = src_addr;
                state_d = RHI;
            end
            RHI: begin
                // Read data lags the address by one cycle: this is the low byte requested in RLO.
                addr_c  = src_addr + AW'(1);
                lo_d    = bus.mem_rdata[7:0];
                state_d = CAP;
            end
            CAP: begin
                hi_d    = bus.mem_rdata[6:0];
                state_d = WLO;
            end
            WLO: begin
                addr_c  = dst_addr;
                we_c    = 1'b1;
                wdata_c = DW'(msg[7:0]);
                if (syn != 4'd0) err_d = err_q + 8'd1;
                state_d = WHI;
            end
            WHI: begin
                addr_c  = dst_addr + AW'(1);
                we_c    = 1'b1;
                wdata_c = DW'({5'b0, msg[10:8]});
                if (idx_q == IW'(NWORDS - 1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = RLO;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_addr  = addr_c;
    assign bus.mem_wr_en = we_c;
    assign bus.mem_wdata = wdata_c;
    assign bus.done      = done_q;
    assign bus.err_cnt   = err_q;
endmodule

// File: tb/tb_hamming_dec_engine.sv
// Randomized bench for hamming_dec_engine: byte-wide memory model, a Hamming reference
// model built on position arithmetic, and a per-cycle compare of writes, done and err_cnt.
`timescale 1ns/1ps
module tb_hamming_dec_engine;
    localparam int NW        = 15;
    localparam int SRC       = 64;
    localparam int DST       = 94;
    localparam int RUN_EDGES = 5 * NW;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hamming_dec_engine_if #(.AW(8), .DW(8)) bus();

    hamming_dec_engine #(
        .AW(8), .DW(8), .SRC_BASE(SRC), .DST_BASE(DST), .NWORDS(NW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Byte memory; the bench owns the port only while the engine is idle.
    logic [7:0] mem [256];
    logic       tb_own, tb_we;
    logic [7:0] tb_addr, tb_wdata, rdata_q;
    assign bus.mem_rdata = rdata_q;

    always @(posedge clk) begin
        if (tb_own) begin
            if (tb_we) mem[tb_addr] <= tb_wdata;
            rdata_q <= mem[tb_addr];
        end else begin
            if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
            rdata_q <= mem[bus.mem_addr];
        end
    end

    int n_cmp  = 0;
    int n_bad  = 0;
    int wr_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference Hamming model: the syndrome is the XOR of the indices of all set bits.
    function automatic bit is_pow2(input int j);
        return (j & (j - 1)) == 0;
    endfunction

    function automatic int ref_syn(input logic [15:0] cw);
        int s = 0;
        for (int j = 1; j < 16; j++) if (cw[j]) s = s ^ j;
        return s;
    endfunction

    function automatic logic [15:0] ref_encode(input logic [10:0] m);
        logic [15:0] cw = '0;
        int k = 0;
        int s;
        for (int j = 1; j < 16; j++) begin
            if (!is_pow2(j)) begin
                cw[j] = m[k];
                k++;
            end
        end
        s = ref_syn(cw);
        for (int b = 0; b < 4; b++) if (((s >> b) & 1) == 1) cw[1 << b] = 1'b1;
        return cw;
    endfunction

    function automatic logic [10:0] ref_extract(input logic [15:0] cw_in);
        logic [15:0] cw = cw_in;
        logic [10:0] m  = '0;
        int k = 0;
        int s = ref_syn(cw_in);
        if (s != 0) cw[s] = ~cw[s];
        for (int j = 1; j < 16; j++) begin
            if (!is_pow2(j)) begin
                m[k] = cw[j];
                k++;
            end
        end
        return m;
    endfunction

    // Data staged for the next run
    logic [10:0] st_orig [NW];
    logic [10:0] st_dec  [NW];
    int          st_err;

    // Cycle-level expectation: a run is RUN_EDGES edges long, 5 per word, writes on phases 3 and 4.
    logic        m_run   = 1'b0;
    logic        m_done  = 1'b0;
    int          m_err   = 0;
    int          m_edges = 0;
    logic [10:0] m_msg [NW];

    always @(posedge clk) begin
        if (reset) begin
            m_run   <= 1'b0;
            m_done  <= 1'b0;
            m_err   <= 0;
            m_edges <= 0;
        end else if (!m_run && bus.init) begin
            m_run   <= 1'b1;
            m_done  <= 1'b0;
            m_edges <= 0;
            m_err   <= st_err;
            m_msg   <= st_dec;
        end else if (m_run) begin
            m_edges <= m_edges + 1;
            if (m_edges + 1 == RUN_EDGES) begin
                m_run  <= 1'b0;
                m_done <= 1'b1;
            end
        end
    end

    int   c_ph, c_w;
    logic c_we;
    always @(negedge clk) begin
        c_ph = m_edges % 5;
        c_w  = m_edges / 5;
        c_we = m_run && (c_ph == 3 || c_ph == 4);
        chk("wr_en", int'(bus.mem_wr_en), int'(c_we));
        if (c_we) begin
            chk("wr_addr", int'(bus.mem_addr), (DST + 2 * c_w + c_ph - 3) % 256);
            chk("wr_data", int'(bus.mem_wdata),
                (c_ph == 3) ? int'(m_msg[c_w][7:0]) : int'(m_msg[c_w][10:8]));
        end
        chk("done", int'(bus.done), int'(m_done));
        if (!m_run) begin
            chk("err_cnt", int'(bus.err_cnt), m_err);
            chk("idle_addr", int'(bus.mem_addr), 0);
            chk("idle_wdata", int'(bus.mem_wdata), 0);
        end
        if (bus.mem_wr_en) begin
            wr_cnt++;
            chk("wr_in_range", int'(bus.mem_addr >= 8'(DST) && bus.mem_addr < 8'(DST + 2 * NW)), 1);
        end
    end

    task automatic mem_wr(input int a, input logic [7:0] d);
        @(negedge clk);
        tb_own   = 1'b1;
        tb_we    = 1'b1;
        tb_addr  = 8'(a);
        tb_wdata = d;
    endtask

    task automatic mem_rd(input int a, output logic [7:0] d);
        @(negedge clk);
        tb_own  = 1'b1;
        tb_we   = 1'b0;
        tb_addr = 8'(a);
        @(negedge clk);
        d = rdata_q;
    endtask

    // mode 0: clean, 1: word w flipped at position w+1, 2: hi[7] forced high
    task automatic stage(input int mode);
        logic [15:0] cw, cwb;
        logic [7:0]  lo, hi;
        st_err = 0;
        for (int w = 0; w < NW; w++) begin
            st_orig[w] = 11'($urandom_range(0, 2047));
            cw = ref_encode(st_orig[w]);
            if (mode == 1) cw[w + 1] = ~cw[w + 1];
            lo = cw[8:1];
            hi = {mode == 2, cw[15:9]};
            mem_wr(SRC + 2 * w, lo);
            mem_wr(SRC + 2 * w + 1, hi);
            cwb = {hi[6:0], lo, 1'b0};
            st_dec[w] = ref_extract(cwb);
            if (ref_syn(cwb) != 0) st_err++;
        end
        for (int b = 0; b < 2 * NW; b++) mem_wr(DST + b, 8'hA5);
        @(negedge clk);
        tb_we  = 1'b0;
        tb_own = 1'b0;
    endtask

    task automatic start();
        @(negedge clk);
        bus.init = 1'b1;
        wr_cnt   = 0;
        @(negedge clk);
        bus.init = 1'b0;
    endtask

    task automatic wait_done(input int extra_at);
        int k = 0;
        while (k < 300) begin
            @(negedge clk);
            k++;
            bus.init = (k == extra_at);
            if (bus.done) break;
        end
        bus.init = 1'b0;
        chk("done_edge", k, RUN_EDGES);
    endtask

    task automatic check_results(input int lit_err);
        logic [7:0] d;
        chk("write_count", wr_cnt, 2 * NW);
        chk("final_err_cnt", int'(bus.err_cnt), lit_err);
        for (int w = 0; w < NW; w++) begin
            mem_rd(DST + 2 * w, d);
            chk("mem_lo", int'(d), int'(st_orig[w][7:0]));
            mem_rd(DST + 2 * w + 1, d);
            chk("mem_hi", int'(d), int'(st_orig[w][10:8]));
        end
        @(negedge clk);
        tb_own = 1'b0;
    endtask

    initial begin
        bus.init = 1'b0;
        tb_own   = 1'b1;
        tb_we    = 1'b0;
        tb_addr  = '0;
        tb_wdata = '0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_wr_en", int'(bus.mem_wr_en), 0);
        chk("rst_addr", int'(bus.mem_addr), 0);
        chk("rst_err_cnt", int'(bus.err_cnt), 0);
        reset = 1'b0;

        chk("model_enc_0", int'(ref_encode(11'h000)), 'h0000);
        chk("model_enc_7ff", int'(ref_encode(11'h7FF)), 'hFFFE);
        chk("model_enc_1", int'(ref_encode(11'h001)), 'h000E);
        chk("model_enc_2", int'(ref_encode(11'h002)), 'h0032);
        chk("model_syn", ref_syn(16'h002E), 5);
        chk("model_fix", int'(ref_extract(16'h002E)), 'h001);

        stage(0); start(); wait_done(0); check_results(0);
        stage(1); start(); wait_done(0); check_results(15);
        stage(2); start(); wait_done(0); check_results(0);
        stage(0); start(); wait_done(20); check_results(0);

        stage(0); start();
        repeat (12) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_wr_en", int'(bus.mem_wr_en), 0);
        chk("midrst_err_cnt", int'(bus.err_cnt), 0);
        reset = 1'b0;
        stage(1); start(); wait_done(0); check_results(15);

        stage(0); start(); wait_done(0); check_results(0);
        stage(1);
        chk("b2b_done_before", int'(bus.done), 1);
        start();
        chk("b2b_done_dropped", int'(bus.done), 0);
        wait_done(0); check_results(15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
